// File: rtl/dtg_sync_monitor.sv
// Receive-side video timing monitor: measures line/frame geometry from hsync/vsync/de,
// recovers active pixel coordinates and tracks lock. Define DTG_MON_ERRCNT_EN for err_count.
module dtg_sync_monitor #(
   parameter bit HSYNC_ACTIVE_LOW = 1'b1,
   parameter bit VSYNC_ACTIVE_LOW = 1'b1,
   parameter int LOCK_FRAMES      = 3,
   parameter int TIMEOUT          = 4095
) (
   input  logic        clock,
   input  logic        rst,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        de_in,
   output logic [11:0] h_total,
   output logic [11:0] v_total,
   output logic [11:0] h_active,
   output logic [11:0] v_active,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y,
   output logic        pix_valid,
   output logic        frame_start,
   output logic        locked,
   output logic        lock_err
`ifdef DTG_MON_ERRCNT_EN
   ,
   output logic [15:0] err_count
`endif
);

   typedef enum logic [1:0] {
      ST_SEARCH = 2'd0,
      ST_TRACK  = 2'd1,
      ST_LOCKED = 2'd2
   } state_t;

   localparam logic [11:0] CNT_MAX    = 12'hFFF;
   localparam logic [11:0] TIMEOUT_M1 = 12'(TIMEOUT - 1);
   localparam logic [15:0] LOCK_AT    = 16'(LOCK_FRAMES - 1);

   function automatic logic [11:0] sat_inc(input logic [11:0] v);
      return (v == CNT_MAX) ? v : v + 12'd1;
   endfunction

   // Syncs are normalised to active-high before edge detection.
   logic hs_a, vs_a;
   logic hs_q, vs_q, de_q;
   logic hs_lead, vs_lead, de_rise, de_fall, first_de;

   assign hs_a    = HSYNC_ACTIVE_LOW ? ~hsync_in : hsync_in;
   assign vs_a    = VSYNC_ACTIVE_LOW ? ~vsync_in : vsync_in;
   assign hs_lead = hs_a & ~hs_q;
   assign vs_lead = vs_a & ~vs_q;
   assign de_rise = de_in & ~de_q;
   assign de_fall = ~de_in & de_q;

   logic [11:0] hcnt_q, hcnt_d;
   logic [11:0] lcnt_q, lcnt_d, lcnt_inc;
   logic [11:0] hde_q, hde_d, hde_inc;
   logic [11:0] vact_q, vact_d, vact_inc;
   logic        line_de_q, line_de_d;
   logic [11:0] h_total_q, h_total_d;
   logic [11:0] v_total_q, v_total_d;
   logic [11:0] h_active_q, h_active_d;
   logic [11:0] v_active_q, v_active_d;
   logic [11:0] pix_x_q, pix_x_d;
   logic [11:0] pix_y_q, pix_y_d;
   logic [11:0] line_len;

   assign line_len = sat_inc(hcnt_q);
   assign first_de = de_in & ~line_de_q;

   // The cycle carrying a leading edge closes the line/frame it ends.
   always_comb begin
      hcnt_d     = hs_lead ? 12'd0 : sat_inc(hcnt_q);
      h_total_d  = hs_lead ? line_len : h_total_q;
      lcnt_inc   = hs_lead ? sat_inc(lcnt_q) : lcnt_q;
      lcnt_d     = vs_lead ? {11'd0, hs_lead} : lcnt_inc;
      v_total_d  = vs_lead ? lcnt_inc : v_total_q;
      hde_inc    = de_in ? sat_inc(hde_q) : hde_q;
      hde_d      = hs_lead ? 12'd0 : hde_inc;
      h_active_d = (hs_lead && (hde_inc != 12'd0)) ? hde_inc : h_active_q;
      line_de_d  = hs_lead ? 1'b0 : (line_de_q | de_in);
      vact_inc   = first_de ? sat_inc(vact_q) : vact_q;
      vact_d     = vs_lead ? 12'd0 : vact_inc;
      v_active_d = vs_lead ? vact_inc : v_active_q;
      pix_x_d    = pix_x_q;
      if (de_rise) begin
         pix_x_d = 12'd0;
      end else if (de_in) begin
         pix_x_d = sat_inc(pix_x_q);
      end
      pix_y_d = pix_y_q;
      if (vs_lead) begin
         pix_y_d = 12'd0;
      end else if (de_fall) begin
         pix_y_d = sat_inc(pix_y_q);
      end
   end

   logic frame_start_q;

   always_ff @(posedge clock) begin
      if (rst) begin
         hs_q          <= 1'b0;
         vs_q          <= 1'b0;
         de_q          <= 1'b0;
         hcnt_q        <= 12'd0;
         lcnt_q        <= 12'd0;
         hde_q         <= 12'd0;
         vact_q        <= 12'd0;
         line_de_q     <= 1'b0;
         h_total_q     <= 12'd0;
         v_total_q     <= 12'd0;
         h_active_q    <= 12'd0;
         v_active_q    <= 12'd0;
         pix_x_q       <= 12'd0;
         pix_y_q       <= 12'd0;
         frame_start_q <= 1'b0;
      end else begin
         hs_q          <= hs_a;
         vs_q          <= vs_a;
         de_q          <= de_in;
         hcnt_q        <= hcnt_d;
         lcnt_q        <= lcnt_d;
         hde_q         <= hde_d;
         vact_q        <= vact_d;
         line_de_q     <= line_de_d;
         h_total_q     <= h_total_d;
         v_total_q     <= v_total_d;
         h_active_q    <= h_active_d;
         v_active_q    <= v_active_d;
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         frame_start_q <= vs_lead;
      end
   end

   state_t      state_q;
   logic [11:0] ref_h_q, ref_v_q;
   logic [15:0] match_q, match_nxt;
   logic        frame_ok_q, lock_err_q;
   logic        line_ok, frame_good, timeout, lose_lock;

   assign line_ok    = (line_len == ref_h_q);
   assign frame_good = frame_ok_q && (!hs_lead || line_ok) && (lcnt_inc == ref_v_q);
   assign timeout    = !hs_lead && (hcnt_q == TIMEOUT_M1);
   assign match_nxt  = match_q + 16'd1;
   assign lose_lock  = (state_q == ST_LOCKED) &&
                       (timeout || (hs_lead && !line_ok) || (vs_lead && (lcnt_inc != ref_v_q)));

   // ref_v starts at 0 so the first full frame always reloads instead of matching.
   always_ff @(posedge clock) begin
      if (rst) begin
         state_q    <= ST_SEARCH;
         ref_h_q    <= 12'd0;
         ref_v_q    <= 12'd0;
         match_q    <= 16'd0;
         frame_ok_q <= 1'b0;
         lock_err_q <= 1'b0;
      end else begin
         lock_err_q <= lose_lock;
         if (vs_lead) begin
            frame_ok_q <= 1'b1;
         end else if (hs_lead && !line_ok) begin
            frame_ok_q <= 1'b0;
         end
         if (timeout || lose_lock) begin
            state_q <= ST_SEARCH;
            match_q <= 16'd0;
         end else begin
            unique case (state_q)
               ST_SEARCH: begin
                  if (vs_lead) begin
                     state_q <= ST_TRACK;
                     ref_h_q <= h_total_d;
                     ref_v_q <= 12'd0;
                     match_q <= 16'd0;
                  end
               end
               ST_TRACK: begin
                  if (vs_lead) begin
                     if (frame_good) begin
                        match_q <= match_nxt;
                        if (match_nxt >= LOCK_AT) begin
                           state_q <= ST_LOCKED;
                        end
                     end else begin
                        ref_h_q <= h_total_d;
                        ref_v_q <= lcnt_inc;
                        match_q <= 16'd0;
                     end
                  end
               end
               ST_LOCKED: begin
               end
               default: state_q <= ST_SEARCH;
            endcase
         end
      end
   end

`ifdef DTG_MON_ERRCNT_EN
   logic [15:0] err_cnt_q;

   always_ff @(posedge clock) begin
      if (rst) begin
         err_cnt_q <= 16'd0;
      end else if (lose_lock && (err_cnt_q != 16'hFFFF)) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_count = err_cnt_q;
`endif

   assign h_total     = h_total_q;
   assign v_total     = v_total_q;
   assign h_active    = h_active_q;
   assign v_active    = v_active_q;
   assign pixel_x     = pix_x_q;
   assign pixel_y     = pix_y_q;
   assign pix_valid   = de_q;
   assign frame_start = frame_start_q;
   assign locked      = (state_q == ST_LOCKED);
   assign lock_err    = lock_err_q;

endmodule

// File: tb/tb_dtg_sync_monitor.sv
// Directed bench for dtg_sync_monitor: active-low instance plus an active-high twin fed
// inverted syncs; a raster generator drives both and immediate assertions check outputs.
module tb_dtg_sync_monitor;

   logic        clock = 1'b0;
   logic        rst;
   logic        hsync, vsync, hsync_p, vsync_p, de;
   logic [11:0] h_total, v_total, h_active, v_active, pixel_x, pixel_y;
   logic        pix_valid, frame_start, locked, lock_err;
   logic [11:0] h_total_p, v_total_p, h_active_p, v_active_p, pixel_x_p, pixel_y_p;
   logic        pix_valid_p, frame_start_p, locked_p, lock_err_p;
`ifdef DTG_MON_ERRCNT_EN
   logic [15:0] err_count, err_count_p;
`endif

   always #5 clock = ~clock;

   dtg_sync_monitor dut (
      .clock(clock), .rst(rst), .hsync_in(hsync), .vsync_in(vsync), .de_in(de),
      .h_total(h_total), .v_total(v_total), .h_active(h_active), .v_active(v_active),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_valid(pix_valid),
      .frame_start(frame_start), .locked(locked), .lock_err(lock_err)
`ifdef DTG_MON_ERRCNT_EN
      , .err_count(err_count)
`endif
   );

   dtg_sync_monitor #(.HSYNC_ACTIVE_LOW(1'b0), .VSYNC_ACTIVE_LOW(1'b0)) dut_p (
      .clock(clock), .rst(rst), .hsync_in(hsync_p), .vsync_in(vsync_p), .de_in(de),
      .h_total(h_total_p), .v_total(v_total_p), .h_active(h_active_p), .v_active(v_active_p),
      .pixel_x(pixel_x_p), .pixel_y(pixel_y_p), .pix_valid(pix_valid_p),
      .frame_start(frame_start_p), .locked(locked_p), .lock_err(lock_err_p)
`ifdef DTG_MON_ERRCNT_EN
      , .err_count(err_count_p)
`endif
   );

   int n_cmp = 0;
   int n_err = 0;
   int h_tot, h_act, hs_beg, hs_end, v_tot, v_act, vs_beg, vs_end;
   int row, col, last_r, last_c, short_row;
   bit short_pending;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic chk_zero(input string tag, input logic [11:0] ht, input logic [11:0] vt,
                           input logic [11:0] ha, input logic [11:0] va, input logic [11:0] px,
                           input logic [11:0] py, input logic pv, input logic fs,
                           input logic lk, input logic le);
      chk({tag, "_h_total"}, ht, 0);
      chk({tag, "_v_total"}, vt, 0);
      chk({tag, "_h_active"}, ha, 0);
      chk({tag, "_v_active"}, va, 0);
      chk({tag, "_pixel_x"}, px, 0);
      chk({tag, "_pixel_y"}, py, 0);
      chk({tag, "_pix_valid"}, pv, 0);
      chk({tag, "_frame_start"}, fs, 0);
      chk({tag, "_locked"}, lk, 0);
      chk({tag, "_lock_err"}, le, 0);
   endtask

   task automatic set_fmt(input int ht, input int ha, input int hb, input int he,
                          input int vt, input int va, input int vb, input int ve);
      h_tot = ht; h_act = ha; hs_beg = hb; hs_end = he;
      v_tot = vt; v_act = va; vs_beg = vb; vs_end = ve;
      row = 0; col = 0;
   endtask

   // Drives one clock of active-high sync levels; dut sees them inverted.
   task automatic drive_clk(input logic hs_a, input logic vs_a, input logic de_a);
      hsync = ~hs_a; vsync = ~vs_a;
      hsync_p = hs_a; vsync_p = vs_a;
      de = de_a;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_clk(1'b0, 1'b0, 1'b0);
   endtask

   task automatic step();
      int len;
      len = (short_pending && row == short_row) ? h_tot - 1 : h_tot;
      last_r = row; last_c = col;
      drive_clk(col >= hs_beg && col <= hs_end, row >= vs_beg && row <= vs_end,
                col < h_act && row < v_act);
      col++;
      if (col >= len) begin
         col = 0;
         if (short_pending && row == short_row) short_pending = 0;
         row = (row + 1 == v_tot) ? 0 : row + 1;
      end
   endtask

   // Steps until pixel (r,c) has just been consumed.
   task automatic run_to(input int r, input int c);
      int guard;
      guard = 0;
      do begin
         step();
         guard++;
      end while (!(last_r == r && last_c == c) && guard < 20000);
      if (guard >= 20000) chk("run_to_reach", (last_r << 16) | last_c, (r << 16) | c);
   endtask

   initial begin
      rst = 1'b1;
      short_pending = 0; short_row = 0;
      set_fmt(800, 640, 656, 751, 6, 4, 4, 4);
      idle(3);
      chk_zero("rst", h_total, v_total, h_active, v_active, pixel_x, pixel_y,
               pix_valid, frame_start, locked, lock_err);
      chk_zero("rst_p", h_total_p, v_total_p, h_active_p, v_active_p, pixel_x_p, pixel_y_p,
               pix_valid_p, frame_start_p, locked_p, lock_err_p);
`ifdef DTG_MON_ERRCNT_EN
      chk("rst_err_count", err_count, 0);
      chk("rst_err_count_p", err_count_p, 0);
`endif
      rst = 1'b0;

      // 640-wide lines, short frames: first partial frame then lock on 4th vsync.
      run_to(4, 0);
      chk("vs1_frame_start", frame_start, 1);
      chk("vs1_locked", locked, 0);
      chk("vs1_partial_v_total", v_total, 4);
      step();
      chk("frame_start_pulse", frame_start, 0);
      run_to(4, 0);
      chk("vs2_locked", locked, 0);
      run_to(0, 0);
      chk("px_first_valid", pix_valid, 1);
      chk("px_first_x", pixel_x, 0);
      chk("px_first_y", pixel_y, 0);
      run_to(2, 639);
      chk("px_last_x", pixel_x, 639);
      chk("px_last_y", pixel_y, 2);
      step();
      chk("px_after_valid", pix_valid, 0);
      chk("px_after_x_hold", pixel_x, 639);
      chk("px_after_y_inc", pixel_y, 3);
      run_to(4, 0);
      chk("vs3_locked", locked, 0);
      run_to(4, 0);
      chk("vs4_locked", locked, 1);
      chk("wide_h_total", h_total, 800);
      chk("wide_v_total", v_total, 6);
      chk("wide_h_active", h_active, 640);
      chk("wide_v_active", v_active, 4);
      chk("pol_locked", locked_p, 1);
      chk("pol_h_total", h_total_p, 800);
      chk("pol_v_total", v_total_p, 6);
      chk("pol_h_active", h_active_p, 640);
      chk("pol_v_active", v_active_p, 4);

      // Format change while locked: spanning line is 143 + 29 clocks.
      run_to(5, 799);
      set_fmt(40, 24, 28, 31, 10, 6, 7, 8);
      run_to(0, 27);
      chk("fmt_pre_locked", locked, 1);
      chk("fmt_pre_lock_err", lock_err, 0);
      step();
      chk("fmt_lock_err", lock_err, 1);
      chk("fmt_locked", locked, 0);
      chk("fmt_h_total", h_total, 172);
      chk("fmt_lock_err_p", lock_err_p, 1);
      step();
      chk("fmt_lock_err_pulse", lock_err, 0);
      run_to(7, 0);
      run_to(7, 0);
      run_to(7, 0);
      chk("small_vs3_locked", locked, 0);
      run_to(7, 0);
      chk("small_vs4_locked", locked, 1);
      chk("small_frame_start", frame_start, 1);
      chk("small_h_total", h_total, 40);
      chk("small_v_total", v_total, 10);
      chk("small_h_active", h_active, 24);
      chk("small_v_active", v_active, 6);

      // One 39-clock line in a locked stream.
      short_row = 2; short_pending = 1;
      run_to(3, 27);
      chk("short_pre_locked", locked, 1);
      chk("short_pre_lock_err", lock_err, 0);
      step();
      chk("short_lock_err", lock_err, 1);
      chk("short_locked", locked, 0);
      chk("short_h_total", h_total, 39);
      step();
      chk("short_lock_err_pulse", lock_err, 0);
      run_to(7, 0);
      run_to(7, 0);
      run_to(7, 0);
      chk("relock_vs3_locked", locked, 0);
      run_to(7, 0);
      chk("relock_vs4_locked", locked, 1);

      // Sync loss: last hsync lead is 11 clocks before the idle run starts.
      run_to(9, 39);
      idle(4083);
      chk("tmo_pre_locked", locked, 1);
      chk("tmo_pre_lock_err", lock_err, 0);
      idle(1);
      chk("tmo_lock_err", lock_err, 1);
      chk("tmo_locked", locked, 0);
`ifdef DTG_MON_ERRCNT_EN
      chk("tmo_err_count", err_count, 3);
`endif
      idle(1);
      chk("tmo_lock_err_pulse", lock_err, 0);
      run_to(7, 0);
      run_to(7, 0);
      run_to(7, 0);
      chk("tmo_relock_vs3", locked, 0);
      run_to(7, 0);
      chk("tmo_relock_vs4", locked, 1);

      // Reset on an active pixel while locked.
      run_to(3, 9);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_zero("midrst", h_total, v_total, h_active, v_active, pixel_x, pixel_y,
               pix_valid, frame_start, locked, lock_err);
`ifdef DTG_MON_ERRCNT_EN
      chk("midrst_err_count", err_count, 0);
`endif
      step();
      chk("midrst_pix_valid", pix_valid, 1);
      chk("midrst_pixel_x", pixel_x, 0);
      run_to(3, 28);
      chk("midrst_partial_h_total", h_total, 18);
      run_to(7, 0);
      chk("midrst_vs1_locked", locked, 0);
      run_to(7, 0);
      run_to(7, 0);
      chk("midrst_vs3_locked", locked, 0);
      run_to(7, 0);
      chk("midrst_vs4_locked", locked, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
